// File: rtl/traffic_light_fsm.sv
// Two-way intersection light sequencer timed purely in slow_tick counts, with a latched pedestrian walk phase.
// Optional night flashing mode is compiled in with `define NIGHT_FLASH_EN (adds the night_mode input).
module traffic_light_fsm #(
  parameter int GREEN_TICKS  = 50,
  parameter int YELLOW_TICKS = 20,
  parameter int ALLRED_TICKS = 10,
  parameter int WALK_TICKS   = 40,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_tick,
  input  logic       ped_req,
`ifdef NIGHT_FLASH_EN
  input  logic       night_mode,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] last_cnt;
  logic             ped_pending_q, ped_pending_d;
  logic [2:0]       ns_light_q, ns_light_d;
  logic [2:0]       ew_light_q, ew_light_d;
  logic             walk_q, walk_d;
  logic             night;
  logic             expire;

`ifdef NIGHT_FLASH_EN
  assign night = night_mode;
`else
  assign night = 1'b0;
`endif

  always_comb begin
    last_cnt = '0;
    case (state_q)
      NS_GREEN, EW_GREEN:   last_cnt = CNT_W'(GREEN_TICKS - 1);
      NS_YELLOW, EW_YELLOW: last_cnt = CNT_W'(YELLOW_TICKS - 1);
      ALL_RED_1, ALL_RED_2: last_cnt = CNT_W'(ALLRED_TICKS - 1);
      PED_WALK:             last_cnt = CNT_W'(WALK_TICKS - 1);
      default:              last_cnt = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    ns_light_d    = ns_light_q;
    ew_light_d    = ew_light_q;
    walk_d        = walk_q;
    ped_pending_d = ped_pending_q | (ped_req && (state_q != PED_WALK));
    expire        = slow_tick && (count_q == last_cnt);

    // FLASH has no duration; without night mode it also doubles as illegal-state recovery.
    if (state_q == FLASH) begin
      count_d = '0;
      if (!night) begin
        state_d = ALL_RED_2;
      end else if (slow_tick) begin
        ns_light_d = ns_light_q ^ YEL;
        ew_light_d = ew_light_q ^ RED;
      end
    end else if (slow_tick) begin
      if (expire) begin
        count_d = '0;
        case (state_q)
          NS_GREEN:  state_d = NS_YELLOW;
          NS_YELLOW: state_d = ALL_RED_1;
          ALL_RED_1: state_d = night ? FLASH : EW_GREEN;
          EW_GREEN:  state_d = EW_YELLOW;
          EW_YELLOW: state_d = ALL_RED_2;
          ALL_RED_2: state_d = night ? FLASH : (ped_pending_q ? PED_WALK : NS_GREEN);
          PED_WALK:  state_d = NS_GREEN;
          default:   state_d = ALL_RED_2;
        endcase
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    if ((state_d == PED_WALK) && (state_q != PED_WALK)) begin
      ped_pending_d = 1'b0;
    end

    // Lights are loaded with the destination state's values on the transition edge itself.
    if (state_d != state_q) begin
      walk_d     = 1'b0;
      ns_light_d = RED;
      ew_light_d = RED;
      case (state_d)
        NS_GREEN:  ns_light_d = GRN;
        NS_YELLOW: ns_light_d = YEL;
        EW_GREEN:  ew_light_d = GRN;
        EW_YELLOW: ew_light_d = YEL;
        PED_WALK:  walk_d = 1'b1;
        FLASH:     ns_light_d = YEL;
        default:   ns_light_d = RED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ALL_RED_2;
      count_q       <= '0;
      ped_pending_q <= 1'b0;
      ns_light_q    <= RED;
      ew_light_q    <= RED;
      walk_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      ped_pending_q <= ped_pending_d;
      ns_light_q    <= ns_light_d;
      ew_light_q    <= ew_light_d;
      walk_q        <= walk_d;
    end
  end

  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign walk     = walk_q;
  assign phase    = state_q;

endmodule
